// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU control path: FSM encoding, micro-instruction layout,
// mux select encoding and the ALU opcodes the datapath top also uses.
package cpu_ctrl_pkg;

  localparam int INSTR_W = 40;

  localparam int HALT_BIT    = 39;
  localparam int IMM_SEL_BIT = 38;
  localparam int WB_EN_BIT   = 37;
  localparam int RSVD_BIT    = 36;
  localparam int OPC_MSB     = 35;
  localparam int OPC_LSB     = 28;
  localparam int RD_MSB      = 27;
  localparam int RD_LSB      = 24;
  localparam int RS_MSB      = 23;
  localparam int RS_LSB      = 20;
  localparam int RT_MSB      = 19;
  localparam int RT_LSB      = 16;
  localparam int IMM_MSB     = 15;
  localparam int IMM_LSB     = 0;

  localparam logic [4:0] SEL_NONE = 5'd0;

  localparam logic [7:0] ADD = 8'h05;
  localparam logic [7:0] SUB = 8'h09;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_EXEC      = 3'd3;
  localparam logic [2:0] ST_WB        = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_STEP_WAIT = 3'd6;

  typedef logic [INSTR_W-1:0] instr_t;

  // Register k is presented to the operand muxes as k+1; 0 means no source.
  function automatic logic [4:0] reg_sel(input logic [3:0] r);
    return {1'b0, r} + 5'd1;
  endfunction

endpackage

// File: rtl/cpu_microsequencer_if.sv
// Start/done control, instruction memory and datapath control bundle of the microsequencer.
// CPU_SEQ_SINGLE_STEP_EN adds the step / step_wait pair.
interface cpu_microsequencer_if #(parameter int PC_W = 8);
  logic            start;
  logic [PC_W-1:0] start_pc;
  logic            busy;
  logic            done;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd;
  logic [39:0]     imem_data;
  logic [15:0]     immediate;
  logic            imm_control;
  logic [4:0]      control1;
  logic [4:0]      control2;
  logic [7:0]      opcode;
  logic            buff_en;
  logic [15:0]     enable;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic            step;
  logic            step_wait;

  modport master (
    output start, start_pc, imem_data, step,
    input  busy, done, imem_addr, imem_rd, immediate, imm_control,
           control1, control2, opcode, buff_en, enable, step_wait
  );
  modport slave (
    input  start, start_pc, imem_data, step,
    output busy, done, imem_addr, imem_rd, immediate, imm_control,
           control1, control2, opcode, buff_en, enable, step_wait
  );
`else
  modport master (
    output start, start_pc, imem_data,
    input  busy, done, imem_addr, imem_rd, immediate, imm_control,
           control1, control2, opcode, buff_en, enable
  );
  modport slave (
    input  start, start_pc, imem_data,
    output busy, done, imem_addr, imem_rd, immediate, imm_control,
           control1, control2, opcode, buff_en, enable
  );
`endif
endinterface

// File: rtl/cpu_instr_decode.sv
// Combinational micro-instruction decode into datapath control fields.
module cpu_instr_decode
  import cpu_ctrl_pkg::*;
(
  input  instr_t      i_ir,
  output logic [4:0]  o_control1,
  output logic [4:0]  o_control2,
  output logic        o_imm_control,
  output logic [15:0] o_immediate,
  output logic [7:0]  o_opcode,
  output logic [15:0] o_wb_mask
);

  // halt is acted on by the sequencer; the reserved bit is don't-care
  logic w_unused;
  assign w_unused = ^{i_ir[HALT_BIT], i_ir[RSVD_BIT]};

  assign o_control1    = reg_sel(i_ir[RS_MSB:RS_LSB]);
  assign o_control2    = i_ir[IMM_SEL_BIT] ? SEL_NONE : reg_sel(i_ir[RT_MSB:RT_LSB]);
  assign o_imm_control = i_ir[IMM_SEL_BIT];
  assign o_immediate   = i_ir[IMM_MSB:IMM_LSB];
  assign o_opcode      = i_ir[OPC_MSB:OPC_LSB];
  assign o_wb_mask     = i_ir[WB_EN_BIT] ? (16'd1 << i_ir[RD_MSB:RD_LSB]) : 16'd0;

endmodule

// File: rtl/cpu_microsequencer.sv
// Fetch/load/exec/writeback sequencer driving the CPU datapath from a micro-instruction memory.
// All outputs are registered from the next state; CPU_SEQ_SINGLE_STEP_EN adds a step gate after WB.
module cpu_microsequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  cpu_microsequencer_if.slave bus
);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [PC_W-1:0] r_pc;
  instr_t          r_ir;
  instr_t          w_ir_next;

  logic            r_busy;
  logic            r_done;
  logic            r_imem_rd;
  logic [15:0]     r_immediate;
  logic            r_imm_control;
  logic [4:0]      r_control1;
  logic [4:0]      r_control2;
  logic [7:0]      r_opcode;
  logic            r_buff_en;
  logic [15:0]     r_enable;

  logic [4:0]      w_control1;
  logic [4:0]      w_control2;
  logic            w_imm_control;
  logic [15:0]     w_immediate;
  logic [7:0]      w_opcode;
  logic [15:0]     w_wb_mask;
  logic            w_dp_active;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (bus.start) w_next = ST_FETCH;
      ST_FETCH:     w_next = ST_LOAD;
      ST_LOAD:      w_next = bus.imem_data[HALT_BIT] ? ST_DONE : ST_EXEC;
      ST_EXEC:      w_next = ST_WB;
`ifdef CPU_SEQ_SINGLE_STEP_EN
      ST_WB:        w_next = ST_STEP_WAIT;
      ST_STEP_WAIT: if (bus.step) w_next = ST_FETCH;
`else
      ST_WB:        w_next = ST_FETCH;
`endif
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Decode the word that will be in IR next cycle so EXEC outputs can be registered.
  assign w_ir_next   = (r_state == ST_LOAD) ? bus.imem_data : r_ir;
  assign w_dp_active = (w_next == ST_EXEC) || (w_next == ST_WB);

  cpu_instr_decode u_decode (
    .i_ir          (w_ir_next),
    .o_control1    (w_control1),
    .o_control2    (w_control2),
    .o_imm_control (w_imm_control),
    .o_immediate   (w_immediate),
    .o_opcode      (w_opcode),
    .o_wb_mask     (w_wb_mask)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_ir          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_imem_rd     <= 1'b0;
      r_immediate   <= '0;
      r_imm_control <= 1'b0;
      r_control1    <= '0;
      r_control2    <= '0;
      r_opcode      <= '0;
      r_buff_en     <= 1'b0;
      r_enable      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && bus.start)
        r_pc <= bus.start_pc;
      else if (r_state == ST_WB)
        r_pc <= r_pc + 1'b1;
      if (r_state == ST_LOAD)
        r_ir <= bus.imem_data;
      r_busy        <= (w_next != ST_IDLE) && (w_next != ST_DONE);
      r_done        <= (w_next == ST_DONE);
      r_imem_rd     <= (w_next == ST_FETCH);
      r_immediate   <= w_dp_active ? w_immediate : '0;
      r_imm_control <= w_dp_active & w_imm_control;
      r_control1    <= w_dp_active ? w_control1 : SEL_NONE;
      r_control2    <= w_dp_active ? w_control2 : SEL_NONE;
      r_opcode      <= w_dp_active ? w_opcode : '0;
      r_buff_en     <= w_dp_active;
      r_enable      <= (w_next == ST_WB) ? w_wb_mask : '0;
    end
  end

`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic r_step_wait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_step_wait <= 1'b0;
    else        r_step_wait <= (w_next == ST_STEP_WAIT);
  end

  assign bus.step_wait = r_step_wait;
`endif

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.imem_addr   = r_pc;
  assign bus.imem_rd     = r_imem_rd;
  assign bus.immediate   = r_immediate;
  assign bus.imm_control = r_imm_control;
  assign bus.control1    = r_control1;
  assign bus.control2    = r_control2;
  assign bus.opcode      = r_opcode;
  assign bus.buff_en     = r_buff_en;
  assign bus.enable      = r_enable;

endmodule

// File: tb/tb_cpu_microsequencer.sv
// Cycle-accurate bench: each program is expanded instruction-by-instruction into an expected
// per-cycle output trace, then replayed against the sequencer with a 1-cycle-latency memory.
module tb_cpu_microsequencer;
  localparam int PC_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  cpu_microsequencer_if #(.PC_W(PC_W)) bus ();
  cpu_microsequencer #(.PC_W(PC_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [39:0] mem [256];

  // Synchronous instruction memory; garbage on the bus when not read.
  always @(posedge clk)
    bus.imem_data <= bus.imem_rd ? mem[bus.imem_addr] : 40'({$urandom(), $urandom()});

  typedef struct packed {
    logic        sw;
    logic        busy;
    logic        done;
    logic [7:0]  addr;
    logic        rd;
    logic [15:0] imm;
    logic        ic;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic [7:0]  op;
    logic        be;
    logic [15:0] en;
  } out_t;

  typedef struct {
    out_t       exp;
    int         ph;
    bit         start_in;
    logic [7:0] spc;
    bit         step_in;
  } cyc_t;

  string ph_name [7] = '{"idle", "fetch", "load", "exec", "wb", "done", "stepw"};

  int errs = 0;
  int checks = 0;
  cyc_t q[$];
  logic [7:0] m_pc = 8'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic out_t obs();
    out_t o;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    o.sw = bus.step_wait;
`else
    o.sw = 1'b0;
`endif
    o.busy = bus.busy;
    o.done = bus.done;
    o.addr = bus.imem_addr;
    o.rd   = bus.imem_rd;
    o.imm  = bus.immediate;
    o.ic   = bus.imm_control;
    o.c1   = bus.control1;
    o.c2   = bus.control2;
    o.op   = bus.opcode;
    o.be   = bus.buff_en;
    o.en   = bus.enable;
    return o;
  endfunction

  function automatic cyc_t mkc(input out_t e, input int ph, input logic [7:0] spc);
    cyc_t c;
    c.exp = e;
    c.ph = ph;
    c.start_in = 1'b0;
    c.spc = spc;
    c.step_in = 1'b0;
    return c;
  endfunction

  function automatic logic [39:0] instr(input bit halt, input bit isel, input bit wb,
      input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
      input logic [15:0] imm);
    return {halt, isel, wb, 1'b0, op, rd, rs, rt, imm};
  endfunction

  // Walk the program from pc0 and lay out the cycles each instruction must produce.
  task automatic build(input logic [7:0] pc0, input int spurious, input int first_wait);
    logic [7:0]  pc;
    logic [39:0] w;
    out_t        e;
    cyc_t        c;
    bit          first = 1'b1;
    q.delete();
    c = mkc(out_t'(0), 0, pc0);
    c.exp.addr = m_pc;
    c.start_in = 1'b1;
    q.push_back(c);
    pc = pc0;
    for (int n = 0; n < 64; n++) begin
      w = mem[pc];
      e = '0; e.busy = 1'b1; e.addr = pc; e.rd = 1'b1;
      q.push_back(mkc(e, 1, pc0));
      e.rd = 1'b0;
      q.push_back(mkc(e, 2, pc0));
      if (w[39]) begin
        q[q.size()-1].start_in = 1'b1;
        e.busy = 1'b0; e.done = 1'b1;
        c = mkc(e, 5, pc0);
        c.start_in = 1'b1;
        q.push_back(c);
        m_pc = pc;
        break;
      end
      e.imm = w[15:0];
      e.ic  = w[38];
      e.c1  = 5'(int'(w[23:20]) + 1);
      e.c2  = w[38] ? 5'd0 : 5'(int'(w[19:16]) + 1);
      e.op  = w[35:28];
      e.be  = 1'b1;
      q.push_back(mkc(e, 3, pc0));
      if (w[37]) e.en = 16'(32'd1 << w[27:24]);
      c = mkc(e, 4, pc0);
      c.step_in = bit'($urandom_range(0, 1));
      q.push_back(c);
      pc = pc + 8'd1;
`ifdef CPU_SEQ_SINGLE_STEP_EN
      begin
        int nw;
        nw = first ? first_wait : int'($urandom_range(1, 4));
        for (int k = 0; k < nw; k++) begin
          e = '0; e.sw = 1'b1; e.busy = 1'b1; e.addr = pc;
          c = mkc(e, 6, pc0);
          c.step_in = (k == nw - 1);
          q.push_back(c);
        end
      end
`endif
      first = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      c = mkc(out_t'(0), 0, pc0);
      c.exp.addr = m_pc;
      q.push_back(c);
    end
    if (spurious > 0 && spurious < q.size() - 3) begin
      q[spurious].start_in = 1'b1;
      q[spurious].spc = 8'($urandom());
    end
  endtask

  task automatic run(input int abort_at);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s@%0d", ph_name[q[i].ph], i), obs(), q[i].exp);
      bus.start    = q[i].start_in;
      bus.start_pc = q[i].spc;
`ifdef CPU_SEQ_SINGLE_STEP_EN
      bus.step     = q[i].step_in;
`endif
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        check("rst_async", obs(), 64'd0);
        bus.start = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
        bus.step  = 1'b0;
`endif
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          check($sformatf("post_rst@%0d", k), obs(), 64'd0);
        end
        m_pc = 8'd0;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0]  pc0;
    logic [39:0] w;
    int          len;
    bus.start    = 1'b0;
    bus.start_pc = '0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    bus.step     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_state", obs(), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_rst", obs(), 64'd0);

    // ADD imm into r1, then halt; first pass is cut by reset in EXEC
    mem[0] = instr(1'b0, 1'b1, 1'b1, cpu_ctrl_pkg::ADD, 4'd1, 4'd0, 4'd0, 16'd10);
    mem[1] = instr(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 16'd0);
    build(8'h00, -1, 10);
    run(3);
    build(8'h00, -1, 10);
    run(-1);

    for (int k = 0; k < 4; k++)
      mem[8'h10 + k] = instr(1'b0, 1'b1, 1'b1, cpu_ctrl_pkg::SUB, 4'(k + 2), 4'(k + 1), 4'd0, 16'd1);
    mem[8'h14] = instr(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 16'd0);
    build(8'h10, -1, 10);
    run(-1);

    mem[8'h20] = instr(1'b0, 1'b0, 1'b0, cpu_ctrl_pkg::ADD, 4'd9, 4'd3, 4'd7, 16'h1234);
    mem[8'h21] = instr(1'b1, 1'b1, 1'b1, 8'hFF, 4'd2, 4'd2, 4'd2, 16'hFFFF);
    build(8'h20, -1, 10);
    run(-1);

    mem[8'hFF] = instr(1'b0, 1'b1, 1'b1, cpu_ctrl_pkg::ADD, 4'd15, 4'd14, 4'd0, 16'h8001);
    mem[8'h00] = instr(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 16'd0);
    build(8'hFF, 3, 10);
    run(-1);

    for (int r = 0; r < 8; r++) begin
      pc0 = 8'($urandom());
      len = int'($urandom_range(1, 6));
      for (int k = 0; k <= len; k++) begin
        w = 40'({$urandom(), $urandom()});
        w[39] = (k == len);
        mem[8'(int'(pc0) + k)] = w;
      end
      build(pc0, int'($urandom_range(1, 12)), int'($urandom_range(1, 10)));
      run(-1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cpu_microsequencer.md
Name: cpu_microsequencer

Overview:
- Programmable control sequencer for the 16-bit CPU datapath (register file, left/right operand muxes, immediate path, ALU, ALU output buffer).
- Replaces hard-wired step FSMs: fetches 40-bit micro-instructions from a synchronous instruction ROM/RAM and decodes them into datapath control.
- Executes one register-transfer operation per instruction until a halt instruction.
- Sits between the top-level start/done control and the datapath control inputs.

Parameters:
- PC_W, 8, program counter / instruction address width; wraps modulo 2^PC_W.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low.
- start  input  1  one-cycle pulse; begins execution at start_pc. Honoured only in IDLE.
- start_pc  input  PC_W  first instruction address.
- busy  output  1  high from the cycle after an accepted start until DONE.
- done  output  1  one-cycle pulse when a halt instruction is decoded.
- imem_addr  output  PC_W  instruction address (current PC).
- imem_rd  output  1  read strobe; data is valid exactly 1 cycle later.
- imem_data  input  40  instruction word.
- immediate  output  16  immediate value to datapath.
- imm_control  output  1  1 = right operand is the immediate.
- control1  output  5  left mux select: 0 = none, k+1 = register k.
- control2  output  5  right mux select; same encoding.
- opcode  output  8  ALU operation code.
- buff_en  output  1  ALU output buffer enable.
- enable  output  16  one-hot register write enable.

Behaviour:
- Instruction fields:
  - [39] halt
  - [38] imm_sel
  - [37] wb_en
  - [36] reserved, ignored
  - [35:28] opcode
  - [27:24] rd
  - [23:20] rs
  - [19:16] rt
  - [15:0] imm
- States: IDLE, FETCH, LOAD, EXEC, WB, DONE.
- IDLE:
  - All datapath outputs 0.
  - On start: PC <= start_pc, go to FETCH. busy rises the following cycle.
- FETCH:
  - imem_addr = PC, imem_rd = 1, go to LOAD.
- LOAD:
  - IR <= imem_data.
  - If imem_data[39] = 1, go to DONE; otherwise go to EXEC.
- EXEC, one cycle:
  - immediate = IR.imm; imm_control = IR.imm_sel.
  - control1 = {1'b0,rs}+1.
  - control2 = 0 if imm_sel, else {1'b0,rt}+1.
  - opcode = IR.opcode; buff_en = 1; enable = 0.
- WB, one cycle:
  - All EXEC outputs held.
  - enable = (1 << rd) if wb_en, else 0.
  - PC <= PC+1, wrapping from 2^PC_W-1 to 0.
  - Go to FETCH.
- DONE:
  - done = 1 for one cycle, busy = 0, datapath outputs 0, go to IDLE.
  - PC is left pointing at the halt address.
- Throughput: 4 cycles per non-halt instruction. A halt costs FETCH+LOAD+DONE.
- Outputs are registered. Outside EXEC/WB, all datapath outputs are 0.
- enable is never multi-hot. It is nonzero only in WB.
- start outside IDLE is ignored; it is not queued.
- start and a pending DONE in the same cycle: start is ignored.
- reset asserted at any time, including mid-instruction:
  - Immediate return to IDLE.
  - PC=0, IR=0.
  - busy, done, imem_rd, enable, buff_en, imm_control, immediate, opcode, control1, control2 all 0.
  - A partially executed instruction is not written back.

Optional Feature:
- Macro: CPU_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit) and output step_wait (1 bit).
  - After WB, the FSM enters STEP_WAIT: step_wait=1, datapath outputs 0.
  - It stays there until step=1, then goes to FETCH.
  - A step asserted on the same cycle as WB is not remembered.
  - reset clears step_wait.
- When undefined: no step port, no STEP_WAIT state; WB goes directly to FETCH.

Decomposition:
- Package cpu_ctrl_pkg:
  - State encoding localparams.
  - Instruction field bit positions.
  - SEL_NONE = 5'd0.
  - Instruction width 40.
  - Shared with the datapath top for opcode constants: ADD = 8'h05, SUB = 8'h09.
- One combinational sub-module, cpu_instr_decode:
  - Input: IR.
  - Outputs: control1, control2, imm_control, immediate, opcode, one-hot wb mask.
- The sequencer registers these outputs and gates them by state.

Test Plan:
1. Reset mid-EXEC -> same cycle: all outputs 0 and state IDLE. After release, no write-back ever occurs for that instruction.
2. Program at 0: ADD imm (imm_sel=1, wb_en=1, op 05, rd=1, rs=0, imm=10), then halt; start_pc=0.
   - EXEC: control1=1, control2=0, imm_control=1, immediate=10, buff_en=1.
   - WB: enable=16'h0002.
   - done pulses 3 cycles after the WB cycle; busy falls with it.
3. Chain of four SUB imm=1 (rd=2..5, rs=1..4), then halt -> enable sequence 0004, 0008, 0010, 0020 with control1 = 2, 3, 4, 5. Exactly 4 cycles between successive WB cycles.
4. Register-register instruction (imm_sel=0, rs=3, rt=7, wb_en=0) -> control2=8, imm_control=0, enable stays 0 in WB.
5. PC_W=8, start_pc=8'hFF, non-halt instruction at FF, halt at 00 -> imem_addr goes FF then 00; done asserted. Also: start pulsed while busy -> no effect on PC or sequence.
6. With CPU_SEQ_SINGLE_STEP_EN: after the first WB, step_wait=1 is held for 10 cycles with no imem_rd. A step pulse gives imem_rd=1 on the next cycle.
